bus_target_mem: RTL and testbench
=================================

// Module: bus_target_mem
// PURPOSE
//  Memory-backed bus target on the CPU-side request bus (req/gnt/start/rdy/mode/addr/data).
//  Sits directly downstream of the CPU core's bus-master port and serves its read tasks.
//  Arbitrates with a req/gnt handshake, then performs single read, single write or
//  burst read. Each transfer takes WAIT_CYC programmable wait states before rdy.
// PARAMETERS
//  AW        8  address width; memory depth = 2**AW words
//  DW        8  data width
//  WAIT_CYC  2  wait states between start and first rdy (0..15)
//  BURST_LEN 4  beats per burst read (2..16)
// PORTS
//  clk       in   1   bus clock, all logic on posedge
//  rst_n     in   1   asynchronous active-low reset
//  req       in   1   master requests bus
//  start     in   1   master starts a transfer (valid only while gnt=1)
//  mode      in   2   00 read, 01 write, 10 burst read, 11 reserved
//  addr      in   AW  transfer address, sampled with start
//  data_in   in   DW  write data, sampled with start (master side of the inout data bus)
//  gnt       out  1   bus granted
//  rdy       out  1   one-cycle pulse per completed beat
//  data_out  out  DW  read data, valid when rdy=1 and data_oe=1
//  data_oe   out  1   target drives data (read beats only)
//  err       out  1   only when BUS_TGT_ERR_EN is defined
// BEHAVIOUR
//  Reset: gnt=0, rdy=0, data_oe=0, data_out=0, err=0; FSM in IDLE; counters cleared.
//  Reset does not clear memory contents.
//  FSM states: IDLE, GRANT, WAIT, RESP.
//  IDLE:  req=1 -> GRANT. gnt rises on the cycle after req is sampled.
//  GRANT: gnt=1.
//   - start=1: latch addr/mode/data_in; WAIT_CYC>0 -> WAIT, else RESP. gnt drops the next cycle.
//   - req=0 and start=0: -> IDLE, gnt drops.
//   - start and req falling in the same cycle: start wins.
//  WAIT:  down-counter loaded with WAIT_CYC-1; at 0 -> RESP. Inputs ignored.
//  RESP:  rdy=1 for exactly one cycle per beat.
//   - Read: data_out=mem[addr_lat], data_oe=1 in the same cycle.
//   - Write: mem[addr_lat]<=data_lat at the rdy edge; data_oe=0.
//   - Burst: BURST_LEN back-to-back rdy beats, no wait states between beats.
//     Address increments by 1 each beat, wraps mod 2**AW (0xFF -> 0x00).
//   - Reserved mode (11): single rdy beat, no memory access, data_oe=0, data_out=0.
//  After the last beat: req=1 -> GRANT (gnt the next cycle), else -> IDLE.
//  Latency: start sampled at edge T -> first rdy high during cycle T+1+WAIT_CYC.
//  A new start while in WAIT or RESP is ignored (gnt=0 there).
//  data_oe is never high outside read rdy beats, so there is no bus contention.
//  Reset mid-transfer: abort immediately to IDLE, outputs go to reset values.
//   - A write whose rdy edge was not reached is not committed.
// CONFIGURATION
//  BUS_TGT_ERR_EN defined:
//   - Port err present; err=1 together with rdy on a reserved-mode beat.
//   - err=1 on a burst beat whose address wrapped past 2**AW-1.
//   - err=0 at all other times.
//  BUS_TGT_ERR_EN undefined:
//   - No err port; reserved mode completes silently; wrapping bursts are legal.
// TESTING
//  1 Reset: rst_n=0 mid-burst -> gnt/rdy/data_oe=0 at once; after release, IDLE, no spurious rdy.
//  2 Write then read, WAIT_CYC=2: write 0x5A to 0x10, then read 0x10.
//    -> rdy 3 cycles after each start; read returns data_out=0xA5? no: returns 0x5A with data_oe=1.
//  3 Burst: preload 0xFE..0x01 with 1,2,3,4; burst read at 0xFE.
//    -> 4 consecutive rdy beats: 1,2,3,4. With BUS_TGT_ERR_EN, err=1 on beats 3 and 4.
//  4 Grant withdraw: req=1 for 1 cycle, then 0 with no start.
//    -> gnt high for 1 cycle, back to IDLE, no rdy.
//  5 Back-to-back: req held high across two reads.
//    -> gnt re-asserts the cycle after the last rdy; second read latency identical.
//  6 WAIT_CYC=0: read at 0xAA holding 0xFF.
//    -> rdy with data_out=0xFF on the cycle after start. Mode 11 -> single rdy, data_oe=0.

Source files
------------

// File: rtl/bus_target_mem.sv
// ---------------------------------------------------------------------------
// bus_target_mem
//  Memory-backed target on the CPU-side request bus. The master asks for the
//  bus with req and gets gnt. While it holds gnt it issues start together with
//  mode/addr/data_in. The target inserts WAIT_CYC wait states and then answers
//  with one rdy pulse per beat. It serves single read (00), single write (01),
//  burst read (10, BURST_LEN beats) and reserved (11, one empty beat).
//
//  Optional feature: define BUS_TGT_ERR_EN to add the err port. err then
//  flags reserved-mode beats and burst beats whose address wrapped past
//  2**AW-1.
//
//  Ports
//   clk      in   bus clock, posedge
//   rst_n    in   asynchronous active-low reset
//   req      in   master requests the bus
//   start    in   transfer start, honoured only while gnt=1
//   mode     in   transfer type (see above)
//   addr     in   transfer address, sampled with start
//   data_in  in   write data, sampled with start
//   gnt      out  bus granted
//   rdy      out  one-cycle pulse per completed beat
//   data_out out  read data, valid when rdy && data_oe
//   data_oe  out  target drives data (read beats only)
//   err      out  error flag (BUS_TGT_ERR_EN only)
// ---------------------------------------------------------------------------
module bus_target_mem #(
   parameter int AW        = 8,
   parameter int DW        = 8,
   parameter int WAIT_CYC  = 2,
   parameter int BURST_LEN = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req,
   input  logic          start,
   input  logic [1:0]    mode,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] data_in,
   output logic          gnt,
   output logic          rdy,
   output logic [DW-1:0] data_out,
   output logic          data_oe
`ifdef BUS_TGT_ERR_EN
   ,output logic         err
`endif
);

   localparam logic [1:0] M_RD  = 2'b00;
   localparam logic [1:0] M_WR  = 2'b01;
   localparam logic [1:0] M_BRD = 2'b10;
   localparam logic [1:0] M_RSV = 2'b11;

   // Wait counter is loaded with WAIT_CYC-1 so WAIT lasts exactly WAIT_CYC cycles.
   localparam logic [3:0] WLOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
   localparam logic [4:0] BLAST = 5'(BURST_LEN - 1);

   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT, S_RESP} state_t;

   state_t        state, state_nx;
   logic [AW-1:0] addr_lat;
   logic [1:0]    mode_lat;
   logic [DW-1:0] data_lat;
   logic [3:0]    wcnt;
   logic [4:0]    bcnt;
   logic          last_beat;
   logic          rd_beat;

   // Memory has no reset; contents survive rst_n.
   logic [DW-1:0] mem [0:(1<<AW)-1];

   assign last_beat = (mode_lat != M_BRD) || (bcnt == BLAST);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (req) state_nx = S_GRANT;
         S_GRANT: begin
            // start outranks a simultaneous req drop
            if (start)     state_nx = (WAIT_CYC > 0) ? S_WAIT : S_RESP;
            else if (!req) state_nx = S_IDLE;
         end
         S_WAIT:  if (wcnt == 4'd0) state_nx = S_RESP;
         S_RESP:  if (last_beat) state_nx = req ? S_GRANT : S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      gnt      = (state == S_GRANT);
      rdy      = (state == S_RESP);
      rd_beat  = rdy && ((mode_lat == M_RD) || (mode_lat == M_BRD));
      data_oe  = rd_beat;
      data_out = rd_beat ? mem[addr_lat] : '0;
   end

   // Transfer datapath: latch on start, count wait states and burst beats
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_lat <= '0;
         mode_lat <= M_RD;
         data_lat <= '0;
         wcnt     <= '0;
         bcnt     <= '0;
      end else begin
         if (state == S_GRANT && start) begin
            addr_lat <= addr;
            mode_lat <= mode;
            data_lat <= data_in;
            wcnt     <= WLOAD;
            bcnt     <= '0;
         end else if (state == S_WAIT && wcnt != 4'd0) begin
            wcnt <= wcnt - 4'd1;
         end else if (state == S_RESP && !last_beat) begin
            addr_lat <= addr_lat + AW'(1);   // wraps mod 2**AW
            bcnt     <= bcnt + 5'd1;
         end
      end
   end

   // Write commits only on the rdy edge; an async reset before it drops the write.
   always_ff @(posedge clk) begin
      if (state == S_RESP && mode_lat == M_WR) mem[addr_lat] <= data_lat;
   end

`ifdef BUS_TGT_ERR_EN
   // Set once a burst has stepped past the top address; holds for the rest of the burst.
   logic wrapped;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wrapped <= 1'b0;
      else if (state == S_GRANT && start) wrapped <= 1'b0;
      else if (state == S_RESP && !last_beat && addr_lat == '1) wrapped <= 1'b1;
   end

   assign err = rdy && ((mode_lat == M_RSV) || (mode_lat == M_BRD && wrapped));
`endif

endmodule

// File: tb/tb_bus_target_mem.sv
// Scoreboard bench: two targets, WAIT_CYC=2 (index 0) and WAIT_CYC=0 (index 1).
// Stimulus pushes expected beats (data, oe, err, absolute rdy cycle) into a
// per-target queue; a negedge monitor pops and compares on every rdy.
module tb_bus_target_mem;

   typedef struct {
      logic       oe;
      logic       chkd;
      logic [7:0] data;
      logic       er;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req [2];
   logic       start [2];
   logic [1:0] mode [2];
   logic [7:0] addr [2];
   logic [7:0] din [2];
   logic       gnt [2];
   logic       rdy [2];
   logic [7:0] dout [2];
   logic       oe [2];
   logic       err [2];

   int   cyc = 0;
   int   nchk = 0;
   int   nfail = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t stg[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   bus_target_mem #(.AW(8), .DW(8), .WAIT_CYC(2), .BURST_LEN(4)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req[0]), .start(start[0]), .mode(mode[0]),
      .addr(addr[0]), .data_in(din[0]), .gnt(gnt[0]), .rdy(rdy[0]),
      .data_out(dout[0]), .data_oe(oe[0])
`ifdef BUS_TGT_ERR_EN
      ,.err(err[0])
`endif
   );

   bus_target_mem #(.AW(8), .DW(8), .WAIT_CYC(0), .BURST_LEN(4)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req[1]), .start(start[1]), .mode(mode[1]),
      .addr(addr[1]), .data_in(din[1]), .gnt(gnt[1]), .rdy(rdy[1]),
      .data_out(dout[1]), .data_oe(oe[1])
`ifdef BUS_TGT_ERR_EN
      ,.err(err[1])
`endif
   );

   function automatic int wc(int i);
      return (i == 0) ? 2 : 0;
   endfunction

   task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, i, act, exp, cyc);
      end
   endtask

   // Queue one expected beat; off is the beat offset from the first rdy.
   task automatic push(logic eoe, logic echk, logic [7:0] d, logic eer, int off);
      exp_t e;
      e.oe = eoe; e.chkd = echk; e.data = d; e.er = eer; e.cyc = off;
      stg.push_back(e);
   endtask

   // Monitor: every rdy must match the head of that target's queue.
   task automatic mon(int i);
      exp_t e;
      logic have;
      have = 1'b0;
      if (rdy[i] === 1'b1) begin
         if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         if (!have) chk("spurious_rdy", i, 32'(rdy[i]), 32'd0);
         else begin
            chk("rdy_cycle", i, 32'(cyc), 32'(e.cyc));
            chk("data_oe", i, 32'(oe[i]), 32'(e.oe));
            if (e.chkd) chk("data_out", i, 32'(dout[i]), 32'(e.data));
`ifdef BUS_TGT_ERR_EN
            chk("err", i, 32'(err[i]), 32'(e.er));
`endif
         end
      end else if (oe[i] !== 1'b0) begin
         chk("oe_without_rdy", i, 32'(oe[i]), 32'd0);
      end
   endtask

   always @(negedge clk) if (rst_n === 1'b1) begin
      mon(0);
      mon(1);
   end

   // Request, wait for gnt, issue start; staged expectations get absolute cycles.
   task automatic start_xfer(int i, logic [1:0] m, logic [7:0] a, logic [7:0] d,
                             logic keep, output int gcyc);
      exp_t e;
      logic got;
      got = 1'b0;
      req[i] = 1'b1;
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         if (gnt[i] === 1'b1) got = 1'b1;
      end
      if (!got) chk("gnt_timeout", i, 32'd0, 32'd1);
      gcyc = cyc;
      start[i] = 1'b1; mode[i] = m; addr[i] = a; din[i] = d;
      while (stg.size() > 0) begin
         e = stg.pop_front();
         e.cyc = cyc + 1 + wc(i) + e.cyc;
         if (i == 0) q0.push_back(e); else q1.push_back(e);
      end
      @(posedge clk); #1;
      start[i] = 1'b0;
      req[i] = keep;
   endtask

   task automatic wait_done(int i);
      for (int k = 0; k < 50 && ((i == 0) ? q0.size() : q1.size()) > 0; k++) @(negedge clk);
      chk("beats_outstanding", i, 32'((i == 0) ? q0.size() : q1.size()), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g1, g2, n;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         req[i] = 0; start[i] = 0; mode[i] = 0; addr[i] = 0; din[i] = 0;
      end
      repeat (3) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         chk("reset_gnt", i, 32'(gnt[i]), 32'd0);
         chk("reset_rdy", i, 32'(rdy[i]), 32'd0);
         chk("reset_oe", i, 32'(oe[i]), 32'd0);
         chk("reset_dout", i, 32'(dout[i]), 32'd0);
`ifdef BUS_TGT_ERR_EN
         chk("reset_err", i, 32'(err[i]), 32'd0);
`endif
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk); #1;

      // Write 0x5A to 0x10, read it back (WAIT_CYC=2)
      push(1'b0, 1'b0, 8'h00, 1'b0, 0);
      start_xfer(0, 2'b01, 8'h10, 8'h5A, 1'b0, g1);
      wait_done(0);
      push(1'b1, 1'b1, 8'h5A, 1'b0, 0);
      start_xfer(0, 2'b00, 8'h10, 8'h00, 1'b0, g1);
      wait_done(0);

      // Preload 0xFE,0xFF,0x00,0x01 then burst across the wrap
      for (int k = 0; k < 4; k++) begin
         push(1'b0, 1'b0, 8'h00, 1'b0, 0);
         start_xfer(0, 2'b01, 8'(8'hFE + k), 8'(k + 1), 1'b0, g1);
         wait_done(0);
      end
      push(1'b1, 1'b1, 8'h01, 1'b0, 0);
      push(1'b1, 1'b1, 8'h02, 1'b0, 1);
      push(1'b1, 1'b1, 8'h03, 1'b1, 2);
      push(1'b1, 1'b1, 8'h04, 1'b1, 3);
      start_xfer(0, 2'b10, 8'hFE, 8'h00, 1'b0, g1);
      wait_done(0);

      // Grant withdrawn without start: gnt for exactly one cycle
      n = 0;
      @(posedge clk); #1; req[0] = 1'b1;
      @(negedge clk); n += int'(gnt[0]);
      @(posedge clk); #1; req[0] = 1'b0;
      for (int k = 0; k < 5; k++) begin @(negedge clk); n += int'(gnt[0]); end
      chk("withdraw_gnt_cycles", 0, 32'(n), 32'd1);
      @(posedge clk); #1;

      // Back-to-back reads with req held
      push(1'b1, 1'b1, 8'h5A, 1'b0, 0);
      start_xfer(0, 2'b00, 8'h10, 8'h00, 1'b1, g1);
      push(1'b1, 1'b1, 8'h04, 1'b0, 0);
      start_xfer(0, 2'b00, 8'h01, 8'h00, 1'b0, g2);
      chk("b2b_regrant_cycle", 0, 32'(g2), 32'(g1 + 4));
      wait_done(0);

      // WAIT_CYC=0: write 0xFF at 0xAA, read it, reserved mode
      push(1'b0, 1'b0, 8'h00, 1'b0, 0);
      start_xfer(1, 2'b01, 8'hAA, 8'hFF, 1'b0, g1);
      wait_done(1);
      push(1'b1, 1'b1, 8'hFF, 1'b0, 0);
      start_xfer(1, 2'b00, 8'hAA, 8'h00, 1'b0, g1);
      wait_done(1);
      push(1'b0, 1'b1, 8'h00, 1'b1, 0);
      start_xfer(1, 2'b11, 8'h33, 8'h77, 1'b0, g1);
      wait_done(1);

      // Reset in the middle of a burst
      push(1'b1, 1'b1, 8'h01, 1'b0, 0);
      push(1'b1, 1'b1, 8'h02, 1'b0, 1);
      push(1'b1, 1'b1, 8'h03, 1'b1, 2);
      push(1'b1, 1'b1, 8'h04, 1'b1, 3);
      start_xfer(0, 2'b10, 8'hFE, 8'h00, 1'b0, g1);
      for (int k = 0; k < 20 && q0.size() > 3; k++) @(negedge clk);
      chk("burst_first_beat", 0, 32'(q0.size()), 32'd3);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("midreset_gnt", 0, 32'(gnt[0]), 32'd0);
      chk("midreset_rdy", 0, 32'(rdy[0]), 32'd0);
      chk("midreset_oe", 0, 32'(oe[0]), 32'd0);
      q0.delete();
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      n = 0;
      for (int k = 0; k < 6; k++) begin @(negedge clk); n += int'(gnt[0]) + int'(rdy[0]); end
      chk("post_reset_quiet", 0, 32'(n), 32'd0);

      // Memory survives reset
      push(1'b1, 1'b1, 8'h5A, 1'b0, 0);
      start_xfer(0, 2'b00, 8'h10, 8'h00, 1'b0, g1);
      wait_done(0);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
